// File: rtl/glitch_alarm_ctrl.sv
// rtl/glitch_alarm_ctrl.sv - clock-glitch alarm response FSM: arm, monitor, confirm, halt/reset, lockout.
// Define GLITCH_ALARM_STICKY_EN to make LOCKOUT exitable only through rst.
module glitch_alarm_ctrl #(
    parameter int NUMBER_OF_CLK   = 4,
    parameter int ARM_CYCLES      = 8,
    parameter int MISMATCH_THRESH = 3,
    parameter int WINDOW_CYCLES   = 64,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm_i,
    input  logic                     clr_i,
    input  logic                     mismatch_i,
    input  logic                     alarm_i,
    output logic [NUMBER_OF_CLK-1:0] cnt_en_o,
    output logic                     core_halt_o,
    output logic                     core_rst_req_o,
    output logic                     irq_o,
    output logic [2:0]               state_o,
    output logic [7:0]               event_cnt_o
);
    localparam int WARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam int WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int HIT_W  = $clog2(MISMATCH_THRESH + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WARMUP  = 3'd1,
        MONITOR = 3'd2,
        CONFIRM = 3'd3,
        RESPOND = 3'd4,
        LOCKOUT = 3'd5
    } state_t;

    state_t                   r_state, w_state;
    logic [WARM_W-1:0]        r_warm, w_warm;
    logic [WIN_W-1:0]         r_win, w_win;
    logic [HOLD_W-1:0]        r_hold, w_hold;
    logic [HIT_W-1:0]         r_hits, w_hits;
    logic [HIT_W-1:0]         w_hits_inc;
    logic [NUMBER_OF_CLK-1:0] r_cnt_en;
    logic                     r_halt;
    logic                     r_rst_req;
    logic [7:0]               r_evt;

    assign w_hits_inc = r_hits + HIT_W'(1);

    always_comb begin
        w_state = r_state;
        w_warm  = r_warm;
        w_win   = r_win;
        w_hold  = r_hold;
        w_hits  = r_hits;
        case (r_state)
            IDLE: begin
                if (arm_i) begin
                    w_state = WARMUP;
                    w_warm  = WARM_W'(ARM_CYCLES - 1);
                end
            end
            WARMUP: begin
                if (!arm_i) begin
                    w_state = IDLE;
                    w_warm  = '0;
                    w_win   = '0;
                    w_hits  = '0;
                end else if (r_warm == '0) begin
                    w_state = MONITOR;
                end else begin
                    w_warm = r_warm - WARM_W'(1);
                end
            end
            MONITOR: begin
                if (alarm_i) begin
                    w_state = RESPOND;
                    w_hold  = HOLD_W'(HOLD_CYCLES - 1);
                end else if (!arm_i) begin
                    w_state = IDLE;
                    w_win   = '0;
                    w_hits  = '0;
                end else if (mismatch_i) begin
                    w_state = CONFIRM;
                    w_hits  = HIT_W'(1);
                    w_win   = WIN_W'(WINDOW_CYCLES - 1);
                end
            end
            CONFIRM: begin
                // alarm outranks disarm, threshold and window expiry
                if (alarm_i || (arm_i && mismatch_i && w_hits_inc == HIT_W'(MISMATCH_THRESH))) begin
                    w_state = RESPOND;
                    w_hold  = HOLD_W'(HOLD_CYCLES - 1);
                    w_win   = '0;
                    w_hits  = '0;
                end else if (!arm_i) begin
                    w_state = IDLE;
                    w_win   = '0;
                    w_hits  = '0;
                end else if (r_win == '0) begin
                    w_state = MONITOR;
                    w_hits  = '0;
                end else begin
                    w_win = r_win - WIN_W'(1);
                    if (mismatch_i) begin
                        w_hits = w_hits_inc;
                    end
                end
            end
            RESPOND: begin
                if (r_hold == '0) begin
                    w_state = LOCKOUT;
                end else begin
                    w_hold = r_hold - HOLD_W'(1);
                end
            end
            LOCKOUT: begin
`ifdef GLITCH_ALARM_STICKY_EN
                w_state = LOCKOUT;
`else
                if (clr_i) begin
                    w_state = IDLE;
                end
`endif
            end
            default: begin
                w_state = LOCKOUT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_warm    <= '0;
            r_win     <= '0;
            r_hold    <= '0;
            r_hits    <= '0;
            r_cnt_en  <= '0;
            r_halt    <= 1'b0;
            r_rst_req <= 1'b0;
            r_evt     <= 8'd0;
        end else begin
            r_state   <= w_state;
            r_warm    <= w_warm;
            r_win     <= w_win;
            r_hold    <= w_hold;
            r_hits    <= w_hits;
            // outputs are decoded from the next state so they line up with state_o
            r_cnt_en  <= (w_state == MONITOR || w_state == CONFIRM) ? '1 : '0;
            r_halt    <= (w_state == RESPOND || w_state == LOCKOUT);
            r_rst_req <= (w_state == RESPOND) && (w_hold == '0);
            if (w_state == RESPOND && r_state != RESPOND && r_evt != 8'hFF) begin
                r_evt <= r_evt + 8'd1;
            end
        end
    end

    assign state_o        = r_state;
    assign cnt_en_o       = r_cnt_en;
    assign core_halt_o    = r_halt;
    assign irq_o          = r_halt;
    assign core_rst_req_o = r_rst_req;
    assign event_cnt_o    = r_evt;
endmodule

// File: tb/tb_glitch_alarm_ctrl.sv
// tb/tb_glitch_alarm_ctrl.sv - directed scoreboard bench for glitch_alarm_ctrl.
module tb_glitch_alarm_ctrl;
    localparam logic [2:0] S_IDLE = 3'd0, S_WARM = 3'd1, S_MON = 3'd2,
                           S_CONF = 3'd3, S_RESP = 3'd4, S_LOCK = 3'd5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       arm_i = 1'b0, clr_i = 1'b0, mismatch_i = 1'b0, alarm_i = 1'b0;
    logic [3:0] cnt_en_o;
    logic       core_halt_o, core_rst_req_o, irq_o;
    logic [2:0] state_o;
    logic [7:0] event_cnt_o;

    always #5 clk = ~clk;

    glitch_alarm_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .arm_i          (arm_i),
        .clr_i          (clr_i),
        .mismatch_i     (mismatch_i),
        .alarm_i        (alarm_i),
        .cnt_en_o       (cnt_en_o),
        .core_halt_o    (core_halt_o),
        .core_rst_req_o (core_rst_req_o),
        .irq_o          (irq_o),
        .state_o        (state_o),
        .event_cnt_o    (event_cnt_o)
    );

    typedef struct {
        string       tag;
        logic [17:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   e_evt  = 0;

    task automatic push_exp(input string tag, input logic [2:0] st, input logic h,
                            input logic rr, input logic [3:0] ce);
        exp_t e;
        e.tag = tag;
        e.v   = {st, h, h, rr, ce, 8'(e_evt)};
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t        g;
        logic [17:0] obs;
        g   = sb.pop_front();
        obs = {state_o, core_halt_o, irq_o, core_rst_req_o, cnt_en_o, event_cnt_o};
        checks++;
        assert (obs === g.v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", g.tag, obs, g.v);
        end
    endtask

    task automatic chk_now(input string tag, input logic [2:0] st, input logic h,
                           input logic rr, input logic [3:0] ce);
        push_exp(tag, st, h, rr, ce);
        pop_cmp();
    endtask

    task automatic cyc(input string tag, input logic [2:0] st, input logic h,
                       input logic rr, input logic [3:0] ce);
        push_exp(tag, st, h, rr, ce);
        @(posedge clk);
        #1;
        pop_cmp();
    endtask

    task automatic arm_up();
        arm_i = 1'b1;
        for (int i = 0; i < 8; i++) cyc("warmup", S_WARM, 1'b0, 1'b0, 4'h0);
        cyc("monitor", S_MON, 1'b0, 1'b0, 4'hF);
    endtask

    task automatic respond_rest();
        for (int i = 0; i < 14; i++) cyc("hold", S_RESP, 1'b1, 1'b0, 4'h0);
        cyc("rst_req", S_RESP, 1'b1, 1'b1, 4'h0);
        cyc("lockout", S_LOCK, 1'b1, 1'b0, 4'h0);
    endtask

    initial begin
        #12;
        chk_now("reset", S_IDLE, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc("idle_hold", S_IDLE, 1'b0, 1'b0, 4'h0);

        arm_up();
        arm_i = 1'b0;
        cyc("disarm_mon", S_IDLE, 1'b0, 1'b0, 4'h0);
        arm_i = 1'b1;
        for (int i = 0; i < 3; i++) cyc("warm_part", S_WARM, 1'b0, 1'b0, 4'h0);
        arm_i = 1'b0;
        cyc("warm_abort", S_IDLE, 1'b0, 1'b0, 4'h0);
        arm_up();

        mismatch_i = 1'b1;
        cyc("hit1", S_CONF, 1'b0, 1'b0, 4'hF);
        cyc("hit2", S_CONF, 1'b0, 1'b0, 4'hF);
        mismatch_i = 1'b0;
        for (int i = 0; i < 62; i++) cyc("window", S_CONF, 1'b0, 1'b0, 4'hF);
        cyc("expire", S_MON, 1'b0, 1'b0, 4'hF);

        mismatch_i = 1'b1;
        cyc("th_hit1", S_CONF, 1'b0, 1'b0, 4'hF);
        mismatch_i = 1'b0;
        for (int i = 0; i < 5; i++) cyc("th_gap1", S_CONF, 1'b0, 1'b0, 4'hF);
        mismatch_i = 1'b1;
        cyc("th_hit2", S_CONF, 1'b0, 1'b0, 4'hF);
        mismatch_i = 1'b0;
        for (int i = 0; i < 3; i++) cyc("th_gap2", S_CONF, 1'b0, 1'b0, 4'hF);
        mismatch_i = 1'b1;
        e_evt++;
        cyc("thresh", S_RESP, 1'b1, 1'b0, 4'h0);
        mismatch_i = 1'b0;
        respond_rest();

        alarm_i = 1'b1; mismatch_i = 1'b1; arm_i = 1'b0;
        for (int i = 0; i < 2; i++) cyc("lock_ignore", S_LOCK, 1'b1, 1'b0, 4'h0);
        alarm_i = 1'b0; mismatch_i = 1'b0; arm_i = 1'b1;
        clr_i = 1'b1;
`ifdef GLITCH_ALARM_STICKY_EN
        cyc("sticky", S_LOCK, 1'b1, 1'b0, 4'h0);
        clr_i = 1'b0;
        cyc("sticky2", S_LOCK, 1'b1, 1'b0, 4'h0);
        rst = 1'b0;
        #1;
        e_evt = 0;
        chk_now("rst_lock", S_IDLE, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        arm_i = 1'b0;
        cyc("after_rst", S_IDLE, 1'b0, 1'b0, 4'h0);
`else
        arm_i = 1'b0;
        cyc("clear", S_IDLE, 1'b0, 1'b0, 4'h0);
        clr_i = 1'b0;
        cyc("clear_idle", S_IDLE, 1'b0, 1'b0, 4'h0);
`endif

        arm_up();
        alarm_i = 1'b1;
        e_evt++;
        cyc("alarm", S_RESP, 1'b1, 1'b0, 4'h0);
        alarm_i = 1'b0;
        respond_rest();

        rst = 1'b0;
        #1;
        e_evt = 0;
        chk_now("rst_lockout", S_IDLE, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        arm_up();

        mismatch_i = 1'b1;
        cyc("sim_hit", S_CONF, 1'b0, 1'b0, 4'hF);
        mismatch_i = 1'b0; alarm_i = 1'b1; arm_i = 1'b0;
        e_evt++;
        cyc("alarm_vs_disarm", S_RESP, 1'b1, 1'b0, 4'h0);
        alarm_i = 1'b0; clr_i = 1'b1; mismatch_i = 1'b1;
        for (int i = 0; i < 5; i++) cyc("resp_ignore", S_RESP, 1'b1, 1'b0, 4'h0);
        clr_i = 1'b0; mismatch_i = 1'b0;
        rst = 1'b0;
        #1;
        e_evt = 0;
        chk_now("abort", S_IDLE, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) cyc("post_abort", S_IDLE, 1'b0, 1'b0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
